// File: rtl/quad_updown_decoder.sv
// Quadrature decoder: synchronises encoder channels A/B, decodes Gray-code
// transitions into step/dir pulses and keeps a wrapping position count.
module quad_updown_decoder #(
  parameter int WIDTH       = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ch_a,
  input  logic             ch_b,
  input  logic             clr,
  input  logic             err_clr,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             step,
  output logic             wrap,
  output logic             err
);

  typedef enum logic {INIT, RUN} state_t;

  localparam int               CW        = $clog2(SYNC_STAGES + 2);
  localparam logic [CW-1:0]    INIT_LAST = CW'(SYNC_STAGES);
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
  localparam logic [WIDTH-1:0] CNT_MAX   = '1;

  state_t                 state;
  logic [CW-1:0]          init_cnt;
  logic [SYNC_STAGES-1:0] sync_a;
  logic [SYNC_STAGES-1:0] sync_b;
  logic [1:0]             cur;
  logic [1:0]             prev;
  logic                   is_up;
  logic                   is_down;
  logic                   is_illegal;

  // Shift registers: bit 0 is the first stage, the MSB is the synchronised output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= {sync_a[SYNC_STAGES-2:0], ch_a};
      sync_b <= {sync_b[SYNC_STAGES-2:0], ch_b};
    end
  end

  assign cur = {sync_a[SYNC_STAGES-1], sync_b[SYNC_STAGES-1]};

  // Up order is 00 -> 10 -> 11 -> 01 -> 00 ({A,B}); down is the reverse.
  always_comb begin
    is_up   = 1'b0;
    is_down = 1'b0;
    case ({prev, cur})
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: is_up   = 1'b1;
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: is_down = 1'b1;
      default: ;
    endcase
    is_illegal = ((prev ^ cur) == 2'b11);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= INIT;
      init_cnt <= '0;
      prev     <= 2'b00;
      count    <= '0;
      dir      <= 1'b1;
      step     <= 1'b0;
      wrap     <= 1'b0;
      err      <= 1'b0;
    end else begin
      prev <= cur;
      step <= 1'b0;
      wrap <= 1'b0;
      case (state)
        INIT: begin
          // Wait until the synchronisers hold real input before decoding.
          if (init_cnt == INIT_LAST) begin
            state <= RUN;
          end else begin
            init_cnt <= init_cnt + 1'b1;
          end
          if (clr) begin
            count <= '0;
          end
          if (err_clr) begin
            err <= 1'b0;
          end
        end
        RUN: begin
          if (is_up) begin
            count <= count + ONE;
            dir   <= 1'b1;
            step  <= 1'b1;
            wrap  <= (count == CNT_MAX);
          end else if (is_down) begin
            count <= count - ONE;
            dir   <= 1'b0;
            step  <= 1'b1;
            wrap  <= (count == '0);
          end
          if (is_illegal) begin
            err <= 1'b1;
          end else if (err_clr) begin
            err <= 1'b0;
          end
          // clr overrides this cycle's count update; step/dir still report it.
          if (clr) begin
            count <= '0;
            wrap  <= 1'b0;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule
